proc_sequencer: RTL and testbench



---
 rtl/proc_sequencer.sv | 120 ++++++++++++
 tb/tb_proc_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_sequencer.sv
// Fetches from a sync ROM and issues to the DIN/Run/Done core; 3 cycles plus core latency per instruction.
// Never issues a new Run until Done returns; a watchdog traps a silent core into ERR.
module proc_sequencer #(
  parameter int                 ADDR_W     = 5,
  parameter logic [ADDR_W-1:0]  START_ADDR = '0,
  parameter int                 MAX_WAIT   = 7
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Stop,
  input  logic              StepMode,
  input  logic              StepGo,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic [15:0]       MemData,
  output logic [15:0]       DIN,
  output logic              Run,
  input  logic              Done,
  output logic              Busy,
  output logic              Halted,
  output logic              Error,
  output logic [15:0]       InstrCount
);

  localparam int WD_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_ISSUE, S_WAIT, S_HOLD, S_HALT, S_ERR
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [WD_W-1:0]   wd;
  logic              stop_flag;

  assign MemAddr = pc;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= S_IDLE;
      pc         <= START_ADDR;
      DIN        <= '0;
      Run        <= 1'b0;
      Busy       <= 1'b0;
      Halted     <= 1'b0;
      Error      <= 1'b0;
      InstrCount <= '0;
      wd         <= '0;
      stop_flag  <= 1'b0;
    end else begin
      Run <= 1'b0;
      // Stop is only remembered while an instruction is in flight; it acts at Done.
      if (Busy && Stop)
        stop_flag <= 1'b1;

      case (state)
        S_IDLE, S_HALT, S_ERR: begin
          if (Start) begin
            pc         <= START_ADDR;
            InstrCount <= '0;
            Halted     <= 1'b0;
            Error      <= 1'b0;
            stop_flag  <= 1'b0;
            Busy       <= 1'b1;
            state      <= S_FETCH;
          end
        end
        S_FETCH: state <= S_LOAD;
        S_LOAD: begin
          if (MemData[15:13] == 3'b111) begin
            Busy   <= 1'b0;
            Halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            DIN   <= MemData;
            Run   <= 1'b1;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wd    <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (Done) begin
            InstrCount <= InstrCount + 16'd1;
            pc         <= pc + 1'b1;
            if (stop_flag || Stop) begin
              stop_flag <= 1'b0;
              Busy      <= 1'b0;
              state     <= S_IDLE;
            end else if (StepMode) begin
              Busy  <= 1'b0;
              state <= S_HOLD;
            end else begin
              state <= S_FETCH;
            end
          end else if (wd == WD_W'(MAX_WAIT - 1)) begin
            Busy  <= 1'b0;
            Error <= 1'b1;
            state <= S_ERR;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        S_HOLD: begin
          if (stop_flag || Stop) begin
            stop_flag <= 1'b0;
            state     <= S_IDLE;
          end else if (StepGo) begin
            Busy  <= 1'b1;
            state <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_sequencer.sv
// Bench for proc_sequencer: ROM and a small core model attached, directed table, corner sequences, random programs.
module tb_proc_sequencer;

  logic        Clock = 1'b0;
  logic        Reset, Start, Stop, StepMode, StepGo, Done;
  logic [4:0]  MemAddr;
  logic [15:0] MemData, DIN, InstrCount;
  logic        Run, Busy, Halted, Error;

  always #5 Clock = ~Clock;

  proc_sequencer dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Stop(Stop),
    .StepMode(StepMode), .StepGo(StepGo), .MemAddr(MemAddr), .MemData(MemData),
    .DIN(DIN), .Run(Run), .Done(Done), .Busy(Busy), .Halted(Halted),
    .Error(Error), .InstrCount(InstrCount)
  );

  logic [15:0] rom [32];
  always @(posedge Clock) MemData <= rom[MemAddr];

  // Core: mv/mvt finish one cycle after Run, add/sub three; opcodes 100-110 never finish.
  function automatic int lat_of(input logic [2:0] op);
    return (op <= 3'd1) ? 1 : ((op <= 3'd3) ? 3 : 0);
  endfunction

  logic [15:0] r [8];
  logic [15:0] opnd;
  int          cnt;
  assign opnd = DIN[12] ? {7'b0, DIN[8:0]} : r[DIN[2:0]];

  always @(posedge Clock) begin
    Done <= 1'b0;
    if (Reset) begin
      cnt <= 0;
      for (int i = 0; i < 8; i++) r[i] <= '0;
    end else if (Run) begin
      case (DIN[15:13])
        3'd0: r[DIN[11:9]] <= opnd;
        3'd1: r[DIN[11:9]] <= {opnd[7:0], r[DIN[11:9]][7:0]};
        3'd2: r[DIN[11:9]] <= r[DIN[11:9]] + opnd;
        3'd3: r[DIN[11:9]] <= r[DIN[11:9]] - opnd;
        default: ;
      endcase
      cnt <= lat_of(DIN[15:13]);
      if (lat_of(DIN[15:13]) == 1) Done <= 1'b1;
    end else if (cnt > 1) begin
      cnt <= cnt - 1;
      if (cnt == 2) Done <= 1'b1;
    end else begin
      cnt <= 0;
    end
  end

  // Monitor: Run/Halted/Error timing relative to the Start edge (that cycle is 1).
  int          cyc = 0, start_cyc = 0;
  int          run_rel[$];
  logic [15:0] run_din[$];
  int          halt_rel = -1, err_rel = -1, dbl_run = 0;
  bit          prev_run = 1'b0;

  always @(posedge Clock) cyc <= cyc + 1;

  function automatic int rel();
    return cyc - start_cyc + 1;
  endfunction

  always @(negedge Clock) begin
    if (Run) begin
      run_rel.push_back(rel());
      run_din.push_back(DIN);
    end
    if (Run && prev_run) dbl_run++;
    prev_run = Run;
    if (Halted && halt_rel < 0) halt_rel = rel();
    if (Error && err_rel < 0) err_rel = rel();
  end

  int ncmp = 0, nfail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_start();
    @(negedge Clock);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    start_cyc = cyc;
    run_rel.delete();
    run_din.delete();
    halt_rel = -1;
    err_rel = -1;
  endtask

  task automatic goto_rel(input int target);
    while (rel() < target) @(negedge Clock);
  endtask

  task automatic pulse(input int which);
    if (which == 0) Stop = 1'b1; else if (which == 1) StepGo = 1'b1; else Start = 1'b1;
    @(negedge Clock);
    Stop = 1'b0; StepGo = 1'b0; Start = 1'b0;
  endtask

  function automatic int last_rel();
    return (run_rel.size() > 0) ? run_rel[run_rel.size()-1] : -1;
  endfunction

  function automatic logic [15:0] last_din();
    return (run_din.size() > 0) ? run_din[run_din.size()-1] : 16'h0;
  endfunction

  typedef struct {
    logic [15:0] w0, w1, w2, w3;
    int          nruns, lrel;
    logic [15:0] ldin;
    int          icnt;
    bit          halted, error;
    int          pc, flag_rel;
    bit          chk_r;
    int          ridx;
    logic [15:0] rval;
  } vec_t;

  vec_t vecs[5];

  // Random-program reference: walk the ROM by opcode with per-instruction cycle costs.
  int          exp_rel[$];
  logic [15:0] exp_din[$];

  task automatic model(output int n, output bit hlt, output bit err, output int pc_end, output int flag);
    int pc, t;
    logic [15:0] w;
    exp_rel.delete();
    exp_din.delete();
    pc = 0; t = 3; n = 0; hlt = 0; err = 0; flag = 0;
    for (int k = 0; k < 32; k++) begin
      w = rom[pc];
      if (w[15:13] == 3'd7) begin
        hlt = 1; flag = t; break;
      end
      exp_rel.push_back(t);
      exp_din.push_back(w);
      if (w[15:13] >= 3'd4) begin
        err = 1; flag = t + 8; break;
      end
      n++;
      t += (w[15:13] <= 3'd1) ? 4 : 6;
      pc = (pc + 1) % 32;
    end
    pc_end = pc;
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Stop = 1'b0; StepMode = 1'b0; StepGo = 1'b0;
    for (int i = 0; i < 32; i++) rom[i] = 16'hE000;
    vecs[0] = '{16'h1005, 16'hE000, 16'hE000, 16'hE000, 1, 3, 16'h1005, 1, 1, 0, 1, 7, 1, 0, 16'd5};
    vecs[1] = '{16'h1203, 16'h5202, 16'hE000, 16'hE000, 2, 7, 16'h5202, 2, 1, 0, 2, 13, 1, 1, 16'd5};
    vecs[2] = '{16'h8000, 16'hE000, 16'hE000, 16'hE000, 1, 3, 16'h8000, 0, 0, 1, 0, 11, 0, 0, 16'd0};
    vecs[3] = '{16'hE000, 16'hE000, 16'hE000, 16'hE000, 0, -1, 16'h0, 0, 1, 0, 0, 3, 0, 0, 16'd0};
    vecs[4] = '{16'h1005, 16'h7003, 16'hC000, 16'hE000, 3, 13, 16'hC000, 2, 0, 1, 2, 21, 1, 0, 16'd2};

    repeat (3) @(negedge Clock);
    chk("rst_run", 32'(Run), 0);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_halted", 32'(Halted), 0);
    chk("rst_error", 32'(Error), 0);
    chk("rst_din", 32'(DIN), 0);
    chk("rst_icnt", 32'(InstrCount), 0);
    chk("rst_pc", 32'(MemAddr), 0);
    Reset = 1'b0;

    // Reset landing in the ISSUE cycle abandons the instruction.
    rom[0] = 16'h1005;
    do_start();
    goto_rel(3);
    chk("issue_run", 32'(Run), 1);
    chk("issue_din", 32'(DIN), 32'h1005);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    chk("midrst_run", 32'(Run), 0);
    chk("midrst_busy", 32'(Busy), 0);
    chk("midrst_din", 32'(DIN), 0);
    chk("midrst_icnt", 32'(InstrCount), 0);
    chk("midrst_pc", 32'(MemAddr), 0);
    chk("midrst_flags", {30'd0, Halted, Error}, 0);

    // Stop during the WAIT of an add: it completes, then back to IDLE.
    rom[0] = 16'h5202; rom[1] = 16'h1005; rom[2] = 16'hE000;
    do_start();
    goto_rel(4);
    pulse(0);
    goto_rel(20);
    chk("stop_runs", 32'(run_rel.size()), 1);
    chk("stop_icnt", 32'(InstrCount), 1);
    chk("stop_pc", 32'(MemAddr), 1);
    chk("stop_busy", 32'(Busy), 0);
    chk("stop_halted", 32'(Halted), 0);

    // Single-step mode.
    rom[0] = 16'h1203; rom[1] = 16'h5202; rom[2] = 16'hE000;
    StepMode = 1'b1;
    do_start();
    goto_rel(5);
    chk("step_hold_busy", 32'(Busy), 0);
    chk("step_hold_icnt", 32'(InstrCount), 1);
    chk("step_hold_pc", 32'(MemAddr), 1);
    goto_rel(12);
    chk("step_nofetch", 32'(run_rel.size()), 1);
    pulse(1);
    goto_rel(19);
    chk("step2_runs", 32'(run_rel.size()), 2);
    chk("step2_rel", 32'(last_rel()), 15);
    chk("step2_icnt", 32'(InstrCount), 2);
    chk("step2_busy", 32'(Busy), 0);
    chk("step2_r1", 32'(r[1]), 5);
    pulse(0);
    pulse(1);
    goto_rel(30);
    chk("step_stop_runs", 32'(run_rel.size()), 2);
    chk("step_stop_halted", 32'(Halted), 0);
    chk("step_stop_pc", 32'(MemAddr), 2);
    StepMode = 1'b0;

    // Directed programs.
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 32; i++) rom[i] = 16'hE000;
      rom[0] = vecs[v].w0; rom[1] = vecs[v].w1; rom[2] = vecs[v].w2; rom[3] = vecs[v].w3;
      do_start();
      goto_rel(30);
      chk($sformatf("v%0d_nruns", v), 32'(run_rel.size()), 32'(vecs[v].nruns));
      chk($sformatf("v%0d_lastrun", v), 32'(last_rel()), 32'(vecs[v].lrel));
      if (vecs[v].nruns > 0) chk($sformatf("v%0d_din", v), 32'(last_din()), 32'(vecs[v].ldin));
      chk($sformatf("v%0d_icnt", v), 32'(InstrCount), 32'(vecs[v].icnt));
      chk($sformatf("v%0d_halted", v), 32'(Halted), 32'(vecs[v].halted));
      chk($sformatf("v%0d_error", v), 32'(Error), 32'(vecs[v].error));
      chk($sformatf("v%0d_pc", v), 32'(MemAddr), 32'(vecs[v].pc));
      chk($sformatf("v%0d_flagrel", v), 32'(vecs[v].halted ? halt_rel : err_rel), 32'(vecs[v].flag_rel));
      if (vecs[v].chk_r) chk($sformatf("v%0d_reg", v), 32'(r[vecs[v].ridx]), 32'(vecs[v].rval));
    end

    // PC wrap with no halt in the ROM.
    for (int i = 0; i < 32; i++) rom[i] = 16'h1400 | 16'(i);
    do_start();
    goto_rel(137);
    chk("wrap_icnt", 32'(InstrCount), 34);
    chk("wrap_pc", 32'(MemAddr), 2);
    chk("wrap_runs", 32'(run_rel.size()), 34);
    chk("wrap_din32", 32'((run_din.size() > 32) ? run_din[32] : 16'hFFFF), 32'h1400);
    chk("wrap_r2", 32'(r[2]), 1);
    chk("wrap_busy", 32'(Busy), 1);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;

    // Random programs against the reference walk; some get a stray Start while busy.
    for (int it = 0; it < 30; it++) begin
      int n, pc_end, flag, hpos, mid;
      bit hlt, err;
      for (int i = 0; i < 32; i++) rom[i] = {3'($urandom_range(0, 3)), 13'($urandom)};
      hpos = $urandom_range(1, 20);
      rom[hpos] = {3'b111, 13'($urandom)};
      if ($urandom_range(0, 3) == 0)
        rom[$urandom_range(0, hpos - 1)] = {3'($urandom_range(4, 6)), 13'($urandom)};
      model(n, hlt, err, pc_end, flag);
      do_start();
      if ($urandom_range(0, 1) == 1) begin
        mid = $urandom_range(1, flag - 1);
        goto_rel(mid);
        pulse(2);
      end
      goto_rel(flag + 10);
      chk($sformatf("rnd%0d_nruns", it), 32'(run_rel.size()), 32'(exp_rel.size()));
      for (int k = 0; k < exp_rel.size() && k < run_rel.size(); k++) begin
        chk($sformatf("rnd%0d_rel%0d", it, k), 32'(run_rel[k]), 32'(exp_rel[k]));
        chk($sformatf("rnd%0d_din%0d", it, k), 32'(run_din[k]), 32'(exp_din[k]));
      end
      chk($sformatf("rnd%0d_icnt", it), 32'(InstrCount), 32'(n));
      chk($sformatf("rnd%0d_pc", it), 32'(MemAddr), 32'(pc_end));
      chk($sformatf("rnd%0d_flags", it), {30'd0, Halted, Error}, {30'd0, hlt, err});
      chk($sformatf("rnd%0d_flagrel", it), 32'(hlt ? halt_rel : err_rel), 32'(flag));
      chk($sformatf("rnd%0d_busy", it), 32'(Busy), 0);
    end

    chk("run_back_to_back", 32'(dbl_run), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
